// File: rtl/neuron_mac_seq.sv
// Single-neuron multiply-accumulate sequencer: streams (activation, weight) pairs
// through FixedFloatMult, accumulates with saturation, adds bias, clamps, optional ReLU.
`timescale 1ns/1ps

module FixedFloatMult #(
  parameter int W_INPUT_A = 8,
  parameter int W_INPUT_B = 32,
  parameter int W_OUTPUT  = 32
) (
  input  logic        [W_INPUT_A-1:0] a_i,
  input  logic signed [W_INPUT_B-1:0] b_i,
  output logic signed [W_OUTPUT-1:0]  p_o
);
  localparam int W_P = W_INPUT_A + W_INPUT_B + 1;

  logic signed [W_P-1:0] a_ext;
  logic signed [W_P-1:0] b_ext;
  logic signed [W_P-1:0] full;
  logic signed [W_P-1:0] rnd;
  logic                  unused_bits;

  assign a_ext = $signed({{(W_P-W_INPUT_A){1'b0}}, a_i});
  assign b_ext = $signed({{(W_P-W_INPUT_B){b_i[W_INPUT_B-1]}}, b_i});
  assign full  = a_ext * b_ext;
  // Adding half an LSB then dropping 8 fraction bits rounds to nearest (ties up).
  assign rnd   = full + W_P'(128);
  assign p_o   = rnd[W_OUTPUT+7:8];
  assign unused_bits = ^{rnd[7:0], rnd[W_P-1:W_OUTPUT+8]};
endmodule

module neuron_mac_seq #(
  parameter int W_INPUT_A = 8,
  parameter int W_INPUT_B = 32,
  parameter int W_OUTPUT  = 32,
  parameter int W_ACC     = 40,
  parameter int W_LEN     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [W_LEN-1:0]     len_i,
  input  logic [W_OUTPUT-1:0]  bias_i,
  input  logic                 relu_en_i,
  output logic                 busy_o,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [W_INPUT_A-1:0] a_i,
  input  logic [W_INPUT_B-1:0] b_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [W_OUTPUT-1:0]  out_data_o,
  output logic                 sat_o
);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FIN, OUT} state_t;

  localparam logic signed [W_ACC-1:0] ACC_MAX = {1'b0, {(W_ACC-1){1'b1}}};
  localparam logic signed [W_ACC-1:0] ACC_MIN = {1'b1, {(W_ACC-1){1'b0}}};
  localparam logic signed [W_ACC:0]   OUT_MAX = {{(W_ACC+2-W_OUTPUT){1'b0}}, {(W_OUTPUT-1){1'b1}}};
  localparam logic signed [W_ACC:0]   OUT_MIN = {{(W_ACC+2-W_OUTPUT){1'b1}}, {(W_OUTPUT-1){1'b0}}};

  state_t                      state_q, state_d;
  logic [W_LEN-1:0]            len_q, len_d;
  logic [W_LEN-1:0]            cnt_q, cnt_d;
  logic [W_OUTPUT-1:0]         bias_q, bias_d;
  logic                        relu_q, relu_d;
  logic signed [W_OUTPUT-1:0]  prod_q, prod_d;
  logic                        prod_vld_q, prod_vld_d;
  logic signed [W_ACC-1:0]     acc_q, acc_d;
  logic                        sticky_q, sticky_d;
  logic                        out_valid_q, out_valid_d;
  logic [W_OUTPUT-1:0]         out_data_q, out_data_d;
  logic                        sat_q, sat_d;

  logic signed [W_OUTPUT-1:0]  prod_w;
  logic signed [W_ACC:0]       acc_sum;
  logic signed [W_ACC:0]       fin_sum;
  logic [W_OUTPUT-1:0]         fin_val;
  logic                        fin_clamp;
  logic                        accept;

  FixedFloatMult #(
    .W_INPUT_A(W_INPUT_A),
    .W_INPUT_B(W_INPUT_B),
    .W_OUTPUT (W_OUTPUT)
  ) u_mult (
    .a_i(a_i),
    .b_i($signed(b_i)),
    .p_o(prod_w)
  );

  assign accept  = (state_q == RUN) && in_valid_i;
  assign acc_sum = $signed({acc_q[W_ACC-1], acc_q})
                 + $signed({{(W_ACC+1-W_OUTPUT){prod_q[W_OUTPUT-1]}}, prod_q});
  assign fin_sum = $signed({acc_q[W_ACC-1], acc_q})
                 + $signed({{(W_ACC+1-W_OUTPUT){bias_q[W_OUTPUT-1]}}, bias_q});

  // Bias add, clamp to result width, then ReLU (so a clamped negative still flags sat).
  always_comb begin
    fin_clamp = 1'b0;
    fin_val   = fin_sum[W_OUTPUT-1:0];
    if (fin_sum > OUT_MAX) begin
      fin_val   = {1'b0, {(W_OUTPUT-1){1'b1}}};
      fin_clamp = 1'b1;
    end else if (fin_sum < OUT_MIN) begin
      fin_val   = {1'b1, {(W_OUTPUT-1){1'b0}}};
      fin_clamp = 1'b1;
    end
    if (relu_q && fin_val[W_OUTPUT-1]) begin
      fin_val = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (len_i != '0) ? RUN : FIN;
      RUN:     if (accept && (cnt_q == len_q - W_LEN'(1))) state_d = DRAIN;
      DRAIN:   state_d = FIN;
      FIN:     state_d = OUT;
      OUT:     if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != IDLE);
    in_ready_o  = (state_q == RUN);
    out_valid_o = out_valid_q;
    out_data_o  = out_data_q;
    sat_o       = sat_q;
  end

  always_comb begin
    len_d       = len_q;
    cnt_d       = cnt_q;
    bias_d      = bias_q;
    relu_d      = relu_q;
    prod_d      = prod_q;
    prod_vld_d  = accept;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sat_d       = sat_q;

    if (state_q == IDLE && start_i) begin
      len_d    = len_i;
      bias_d   = bias_i;
      relu_d   = relu_en_i;
      cnt_d    = '0;
      acc_d    = '0;
      sticky_d = 1'b0;
    end else if (prod_vld_q) begin
      if (acc_sum[W_ACC] != acc_sum[W_ACC-1]) begin
        acc_d    = acc_sum[W_ACC] ? ACC_MIN : ACC_MAX;
        sticky_d = 1'b1;
      end else begin
        acc_d = acc_sum[W_ACC-1:0];
      end
    end

    if (accept) begin
      prod_d = prod_w;
      cnt_d  = cnt_q + W_LEN'(1);
    end

    if (state_q == FIN) begin
      out_data_d  = fin_val;
      sat_d       = sticky_q | fin_clamp;
      sticky_d    = sticky_q | fin_clamp;
      out_valid_d = 1'b1;
    end else if (state_q == OUT && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      cnt_q       <= '0;
      bias_q      <= '0;
      relu_q      <= 1'b0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      bias_q      <= bias_d;
      relu_q      <= relu_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
    end
  end
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: hand-computed results, latency, stall,
// saturation, ReLU, ignored start and mid-run reset.
`timescale 1ns/1ps

module tb_neuron_mac_seq;
  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [9:0]  len_i;
  logic [31:0] bias_i;
  logic        relu_en_i;
  logic        busy_o;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  a_i;
  logic [31:0] b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic        sat_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  logic saw_ready;

  neuron_mac_seq dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .len_i(len_i), .bias_i(bias_i),
    .relu_en_i(relu_en_i), .busy_o(busy_o), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .a_i(a_i), .b_i(b_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .sat_o(sat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (in_ready_o) saw_ready = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [9:0] len, input logic [31:0] bias, input logic relu);
    start_i = 1'b1; len_i = len; bias_i = bias; relu_en_i = relu;
    tick();
    start_i = 1'b0;
    t0 = cyc;
    chk("start_busy", {31'd0, busy_o}, 32'd1);
    chk("start_in_ready", {31'd0, in_ready_o}, (len != 10'd0) ? 32'd1 : 32'd0);
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [31:0] b);
    int n;
    n = 0;
    in_valid_i = 1'b1; a_i = a; b_i = b;
    while (!in_ready_o && n < 20) begin
      tick();
      n++;
    end
    chk("pair_ready", {31'd0, in_ready_o}, 32'd1);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp_data,
                             input logic exp_sat, input int exp_lat);
    int n;
    n = 0;
    while (!out_valid_o && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, out_valid_o}, 32'd1);
    chk({tag, "_latency"}, cyc - t0, exp_lat);
    chk({tag, "_data"}, out_data_o, exp_data);
    chk({tag, "_sat"}, {31'd0, sat_o}, {31'd0, exp_sat});
    $display("txn %s: data=%h sat=%0d latency=%0d", tag, out_data_o, sat_o, cyc - t0);
  endtask

  task automatic handshake(input string tag);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk({tag, "_hs_valid"}, {31'd0, out_valid_o}, 32'd0);
    chk({tag, "_hs_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; len_i = '0; bias_i = '0; relu_en_i = 1'b0;
    in_valid_i = 1'b0; a_i = '0; b_i = '0; out_ready_i = 1'b0; saw_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_out_data", out_data_o, 32'd0);
    chk("rst_sat", {31'd0, sat_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single pair
    do_start(10'd1, 32'd0, 1'b0);
    send_pair(8'h7d, 32'h000a66c4);
    wait_result("one_pair", 32'h0005142e, 1'b0, 3);
    handshake("one_pair");

    // Two pairs with a two-cycle input gap
    do_start(10'd2, 32'd0, 1'b0);
    send_pair(8'h7d, 32'h000a66c4);
    tick();
    tick();
    send_pair(8'h01, 32'h000ab0f1);
    wait_result("gap", 32'h00051edf, 1'b0, 6);
    handshake("gap");

    // Negative product, ReLU off then on (out_ready high early)
    do_start(10'd1, 32'd0, 1'b0);
    send_pair(8'h3e, 32'hfff7e1c5);
    wait_result("neg", 32'hfffe08ae, 1'b0, 3);
    handshake("neg");
    out_ready_i = 1'b1;
    do_start(10'd1, 32'd0, 1'b1);
    send_pair(8'h3e, 32'hfff7e1c5);
    out_ready_i = 1'b1;
    wait_result("relu", 32'h00000000, 1'b0, 3);
    tick();
    out_ready_i = 1'b0;
    chk("relu_early_ready_valid", {31'd0, out_valid_o}, 32'd0);

    // Zero-length command with a pair offered that must not be consumed
    tick();
    saw_ready = 1'b0;
    in_valid_i = 1'b1; a_i = 8'h55; b_i = 32'h00001000;
    do_start(10'd0, 32'h00001234, 1'b0);
    wait_result("len0", 32'h00001234, 1'b0, 1);
    handshake("len0");
    in_valid_i = 1'b0;
    chk("len0_no_ready", {31'd0, saw_ready}, 32'd0);

    // Bias saturation, held output and ignored start
    do_start(10'd1, 32'h7fffffff, 1'b0);
    send_pair(8'h7d, 32'h000a66c4);
    wait_result("sat", 32'h7fffffff, 1'b1, 3);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        start_i = 1'b1; len_i = 10'd0; bias_i = 32'h0000abcd;
      end
      tick();
      start_i = 1'b0;
      chk("hold_valid", {31'd0, out_valid_o}, 32'd1);
      chk("hold_data", out_data_o, 32'h7fffffff);
      chk("hold_sat", {31'd0, sat_o}, 32'd1);
    end
    handshake("sat");
    tick();
    tick();
    chk("ignored_start_valid", {31'd0, out_valid_o}, 32'd0);
    chk("ignored_start_busy", {31'd0, busy_o}, 32'd0);

    // Reset mid-run after 3 of 8 pairs, with a pair still offered
    do_start(10'd8, 32'd0, 1'b0);
    send_pair(8'h7d, 32'h000a66c4);
    send_pair(8'h7d, 32'h000a66c4);
    send_pair(8'h7d, 32'h000a66c4);
    in_valid_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready_o}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("midrst_out_data", out_data_o, 32'd0);
    chk("midrst_sat", {31'd0, sat_o}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_busy", {31'd0, busy_o}, 32'd0);
    chk("postrst_in_ready", {31'd0, in_ready_o}, 32'd0);
    in_valid_i = 1'b0;
    do_start(10'd1, 32'd0, 1'b0);
    send_pair(8'h7d, 32'h000a66c4);
    wait_result("after_rst", 32'h0005142e, 1'b0, 3);
    handshake("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
